// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit frame controller
// Sequences start/data/parity/stop bits and drives the external TX serializer.
module uart_tx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  ARSTn,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] ser_DATA,
    output logic                  TX_OUT,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  w_accept;
    logic                  w_tx;
    logic                  w_busy;
    logic                  w_ser_en;

    // A new byte is only taken while the line is idle or sending its stop bit.
    assign w_accept = DATA_VALID && ((r_state == S_IDLE) || (r_state == S_STOP));

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_bit <= (^P_DATA) ^ PAR_TYP;
        end
    end

    always_comb begin
        w_next   = S_IDLE;
        w_tx     = 1'b1;
        w_busy   = 1'b0;
        w_ser_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = w_accept ? S_START : S_IDLE;
            end
            S_START: begin
                w_tx     = 1'b0;
                w_busy   = 1'b1;
                w_ser_en = 1'b1;
                w_next   = S_DATA;
            end
            S_DATA: begin
                // ser_done is also high during START, so it is only honoured here.
                w_tx     = ser_data;
                w_busy   = 1'b1;
                w_ser_en = 1'b1;
                if (ser_done) begin
                    w_next = r_par_en ? S_PARITY : S_STOP;
                end else begin
                    w_next = S_DATA;
                end
            end
            S_PARITY: begin
                w_tx   = r_par_bit;
                w_busy = 1'b1;
                w_next = S_STOP;
            end
            S_STOP: begin
                w_busy = 1'b1;
                w_next = w_accept ? S_START : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign TX_OUT   = w_tx;
    assign busy     = w_busy;
    assign ser_en   = w_ser_en;
    assign ser_DATA = r_data;

endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Frame controller for the UART transmit path. It accepts a parallel byte on a single-cycle valid strobe, latches the byte and its parity configuration, and sequences the external `TX_Serializer` through `ser_en`/`ser_done`. It muxes start, data, parity and stop bits onto the serial line `TX_OUT`. It sits between the system-side TX register interface and the UART pin.

## Interface
- `DATA_WIDTH`, 8: payload width. Must be 8 because the serializer's `ser_done` marks bit index 7.
- `clk`  in  1  transmit clock (UART TX bit clock); every state change happens on the rising edge.
- `ARSTn`  in  1  asynchronous active-low reset.
- `P_DATA`  in  DATA_WIDTH  parallel byte to send.
- `DATA_VALID`  in  1  one-cycle strobe; `P_DATA`, `PAR_EN` and `PAR_TYP` are valid in this cycle.
- `PAR_EN`  in  1  1 = append parity bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `ser_done`  in  1  from serializer; 1 when its bit index is 7.
- `ser_data`  in  1  from serializer; current data bit.
- `ser_en`  out  1  enable to serializer.
- `ser_DATA`  out  DATA_WIDTH  latched byte driven to the serializer `DATA` input.
- `TX_OUT`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: when `DATA_VALID`=1 in IDLE or STOP:
  - latch `P_DATA` into `ser_DATA`;
  - latch `PAR_EN`;
  - latch the parity bit: even = XOR of the byte, odd = inverted XOR;
  - next state is START.
- `DATA_VALID` in START, DATA or PARITY is ignored. Latched values do not change.
- IDLE:
  - `TX_OUT`=1, `busy`=0, `ser_en`=0.
  - Goes to START on acceptance, otherwise stays.
- START:
  - `TX_OUT`=0, `busy`=1, `ser_en`=1, so the serializer index moves from 7 to 0 at the end of this cycle.
  - Always goes to DATA.
- DATA:
  - `TX_OUT`=`ser_data`, `busy`=1, `ser_en`=1.
  - `ser_done` is evaluated only in this state. In START the serializer index is also 7, so `ser_done` there must be ignored.
  - When `ser_done`=1, bit 7 is on the line. Next state is PARITY if the latched `PAR_EN`=1, otherwise STOP.
- PARITY:
  - `TX_OUT`=latched parity bit, `busy`=1, `ser_en`=0, which returns the serializer index to 7.
  - Always goes to STOP.
- STOP:
  - `TX_OUT`=1, `busy`=1, `ser_en`=0.
  - Goes to START on acceptance (back-to-back frame, no idle gap), otherwise to IDLE.
- Output decode:
  - `TX_OUT`, `busy` and `ser_en` are decoded from the state register only, plus `ser_data` in DATA.
  - No input affects `TX_OUT` combinationally except `ser_data`.
- Illegal or unused state encodings recover to IDLE on the next edge, with IDLE outputs.

## Timing
- Reset values: state IDLE, `TX_OUT`=1, `busy`=0, `ser_en`=0, `ser_DATA`=0, latched parity=0, latched `PAR_EN`=0.
- Reset asserted mid-frame aborts immediately. The line returns to 1 asynchronously, and the serializer is reset by its own `ARSTn`.
- Latency: with the strobe in cycle 0, the start bit is on `TX_OUT` in cycle 1, and data bits 0..7 (LSB first) are on the line in cycles 2..9.
  - With parity: parity in cycle 10, stop in cycle 11, `busy` falls in cycle 12.
  - Without parity: stop in cycle 10, `busy` falls in cycle 11.
- Frame length: 11 cycles with parity, 10 without. Back-to-back frames are exactly 11 or 10 cycles apart.
- `ser_en` is high for exactly 9 consecutive cycles per frame: START plus 8 DATA cycles.
- Parity configuration is frozen at acceptance. Changing `PAR_EN` or `PAR_TYP` mid-frame has no effect.

## Test plan
- Reset, then `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0, one strobe -> `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,0,1 over cycles 1–11; `busy` high for cycles 1–11.
- `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=1 -> same frame with parity bit 1 in cycle 10.
- `P_DATA`=0x3C, `PAR_EN`=0 -> 0,0,0,1,1,1,1,0,0,1 (10 cycles); no parity cycle; `ser_en` high for cycles 1–9.
- Back-to-back: second strobe with 0xFF during the STOP cycle of the first frame -> next START immediately follows STOP; `busy` never drops; second data bits all 1.
- Strobe with 0x00 during DATA of the 0xA5 frame -> ignored; the 0xA5 frame completes unchanged; `busy` then falls.
- `ARSTn` pulsed low in cycle 5 of a frame -> `TX_OUT`=1, `busy`=0, `ser_en`=0 immediately. A new strobe after release produces a clean full frame.
